// File: rtl/dmc_output_unit.sv
// DMC output unit: shifts sample-buffer bytes out LSB-first and steps a
// saturating 7-bit DAC counter by +/-2 per bit on each output-rate tick.
module dmc_output_unit (
    input  logic       CLK,
    input  logic       RES,
    input  logic       tick,
    input  logic       buf_full,
    input  logic [7:0] buf_data,
    output logic       buf_take,
    input  logic       load_en,
    input  logic [6:0] load_val,
    output logic [6:0] out,
    output logic       silence,
    output logic [2:0] bits_left
);

    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       sil_q, sil_d;
    logic [6:0] out_q, out_d;
    logic       take_q, take_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sil_d   = sil_q;
        out_d   = out_q;
        take_d  = 1'b0;

        if (tick) begin
            // Saturate at the rails rather than wrap.
            if (!sil_q) begin
                if (shift_q[0] && (out_q <= 7'd125)) begin
                    out_d = out_q + 7'd2;
                end else if (!shift_q[0] && (out_q >= 7'd2)) begin
                    out_d = out_q - 7'd2;
                end
            end

            shift_d = {1'b0, shift_q[7:1]};

            if (cnt_q != 3'd0) begin
                cnt_d = cnt_q - 3'd1;
            end else begin
                cnt_d = 3'd7;
                if (buf_full) begin
                    shift_d = buf_data;
                    sil_d   = 1'b0;
                    take_d  = 1'b1;
                end else begin
                    shift_d = 8'd0;
                    sil_d   = 1'b1;
                end
            end
        end

        // Direct DAC write overrides any step on the same edge.
        if (load_en) begin
            out_d = load_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            shift_q <= 8'd0;
            cnt_q   <= 3'd0;
            sil_q   <= 1'b1;
            out_q   <= 7'd0;
            take_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sil_q   <= sil_d;
            out_q   <= out_d;
            take_q  <= take_d;
        end
    end

    assign out       = out_q;
    assign silence   = sil_q;
    assign bits_left = cnt_q;
    assign buf_take  = take_q;

endmodule

// File: tb/tb_dmc_output_unit.sv
// Bench for dmc_output_unit: per-cycle comparison against a bit-index model
// plus directed scenarios with hand-computed DAC values.
module tb_dmc_output_unit;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic       tick = 1'b0;
    logic       buf_full = 1'b0;
    logic [7:0] buf_data = 8'd0;
    logic       buf_take;
    logic       load_en = 1'b0;
    logic [6:0] load_val = 7'd0;
    logic [6:0] out;
    logic       silence;
    logic [2:0] bits_left;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    logic last_take;

    // Model: byte being played, index of the next bit to play, silence flag.
    int         m_out = 0;
    int         m_idx = 7;
    bit         m_sil = 1'b1;
    logic [7:0] m_byte = 8'd0;
    bit         m_take = 1'b0;

    dmc_output_unit dut (
        .CLK       (CLK),
        .RES       (RES),
        .tick      (tick),
        .buf_full  (buf_full),
        .buf_data  (buf_data),
        .buf_take  (buf_take),
        .load_en   (load_en),
        .load_val  (load_val),
        .out       (out),
        .silence   (silence),
        .bits_left (bits_left)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        int         o;
        int         idx;
        bit         sil;
        bit         tk;
        logic [7:0] by;
        o   = m_out;
        idx = m_idx;
        sil = m_sil;
        by  = m_byte;
        tk  = 1'b0;
        if (RES) begin
            o   = 0;
            idx = 7;
            sil = 1'b1;
            by  = 8'd0;
        end else begin
            if (tick) begin
                if (!sil) begin
                    if (by[idx]) begin
                        if (o + 2 <= 127) o = o + 2;
                    end else begin
                        if (o - 2 >= 0) o = o - 2;
                    end
                end
                if (idx == 7) begin
                    idx = 0;
                    if (buf_full) begin
                        by  = buf_data;
                        sil = 1'b0;
                        tk  = 1'b1;
                    end else begin
                        sil = 1'b1;
                    end
                end else begin
                    idx = idx + 1;
                end
            end
            if (load_en) o = int'(load_val);
        end
        m_out  <= o;
        m_idx  <= idx;
        m_sil  <= sil;
        m_byte <= by;
        m_take <= tk;
    end

    always @(negedge CLK) begin
        if (started) begin
            checks = checks + 1;
            if (out !== 7'(m_out) || silence !== m_sil || bits_left !== 3'(7 - m_idx)
                || buf_take !== m_take) begin
                errors = errors + 1;
                $display("FAIL model_cmp t=%0t: out=%0d sil=%0b bl=%0d take=%0b required out=%0d sil=%0b bl=%0d take=%0b",
                         $time, out, silence, bits_left, buf_take, m_out, m_sil, 7 - m_idx,
                         m_take);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Tick for one cycle, then idle one cycle; buf_take is captured after the tick edge.
    task automatic do_tick();
        tick = 1'b1;
        @(posedge CLK);
        #1;
        last_take = buf_take;
        tick      = 1'b0;
        load_en   = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [6:0] v);
        load_en  = 1'b1;
        load_val = v;
        @(posedge CLK);
        #1;
        load_en = 1'b0;
    endtask

    int exp_a5[8] = '{66, 64, 66, 64, 62, 64, 62, 64};

    initial begin
        RES = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        started = 1'b1;
        chk("reset_out", int'(out), 0);
        chk("reset_sil", int'(silence), 1);
        chk("reset_bl", int'(bits_left), 0);
        chk("reset_take", int'(buf_take), 0);
        RES = 1'b0;

        // Stream 8'hFF from reset.
        buf_full = 1'b1;
        buf_data = 8'hFF;
        do_tick();
        chk("t1_take", int'(last_take), 1);
        chk("t1_sil", int'(silence), 0);
        chk("t1_out", int'(out), 0);
        chk("t1_take_drop", int'(buf_take), 0);
        for (int k = 2; k <= 9; k++) begin
            do_tick();
            chk("ff_ramp", int'(out), 2 * (k - 1));
        end
        chk("t9_take", int'(last_take), 1);

        // Upper saturation: FF byte already loaded, start at 124.
        do_load(7'd124);
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) buf_data = 8'h00;
            do_tick();
            chk("sat_hi", int'(out), 126);
        end

        // Lower saturation: 00 byte from 1.
        do_load(7'd1);
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) buf_data = 8'hA5;
            do_tick();
            chk("sat_lo", int'(out), 1);
        end

        // A5 pattern from 64.
        do_load(7'd64);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) buf_full = 1'b0;
            do_tick();
            chk("a5_walk", int'(out), exp_a5[k]);
        end
        chk("empty_sil", int'(silence), 1);
        chk("empty_take", int'(last_take), 0);

        // Silent cycle: out frozen regardless of buf_data.
        for (int k = 1; k <= 8; k++) begin
            buf_data = 8'($urandom);
            if (k == 8) begin
                buf_full = 1'b1;
                buf_data = 8'h01;
            end
            do_tick();
            chk("silent_hold", int'(out), 64);
        end
        chk("refill_sil", int'(silence), 0);
        chk("refill_take", int'(last_take), 1);

        // Load coincident with an up-step tick.
        do_load(7'd10);
        load_en  = 1'b1;
        load_val = 7'h55;
        do_tick();
        chk("load_prio_out", int'(out), 85);
        chk("load_prio_bl", int'(bits_left), 6);

        // Reset mid-cycle coincident with tick.
        repeat (3) do_tick();
        do_load(7'd40);
        chk("pre_rst_bl", int'(bits_left), 3);
        chk("pre_rst_out", int'(out), 40);
        RES  = 1'b1;
        tick = 1'b1;
        @(posedge CLK);
        #1;
        tick = 1'b0;
        RES  = 1'b0;
        chk("rst_out", int'(out), 0);
        chk("rst_sil", int'(silence), 1);
        chk("rst_bl", int'(bits_left), 0);
        chk("rst_take", int'(buf_take), 0);
        repeat (3) @(posedge CLK);
        #1;
        started = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
